// File: rtl/mem_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_arbiter
// Purpose  : Byte-serial memory controller. Arbitrates between the
//            instruction fetcher (4-byte reads) and the LSU (1/2/4-byte
//            loads and stores), drives the registered byte bus
//            (mem_a/mem_dout/mem_wr), assembles little-endian read data and
//            returns a one-cycle finish pulse to the owner.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            rdy                 - global ready; low freezes all state
//            rollback            - flush; abandons reads, never stores
//            if_enable/if_addr   - fetch request (always 4 bytes)
//            if_finish/if_data   - fetch completion pulse and data
//            lsu_enable/lsu_wr/lsu_size/lsu_addr/lsu_wdata - LSU request
//            lsu_finish/lsu_rdata - LSU completion pulse and load data
//            mem_din/mem_dout/mem_a/mem_wr - external byte bus
//            io_buffer_full      - UART back-pressure for IO stores
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              if_enable,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_finish,
    output logic [DATA_W-1:0] if_data,
    input  logic              lsu_enable,
    input  logic              lsu_wr,
    input  logic [2:0]        lsu_size,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_finish,
    output logic [DATA_W-1:0] lsu_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;

    localparam logic c_OWN_IF  = 1'b0;
    localparam logic c_OWN_LSU = 1'b1;

    logic [1:0]        r_state,      w_state_nxt;
    logic              r_owner,      w_owner_nxt;
    logic [ADDR_W-1:0] r_base,       w_base_nxt;
    logic [2:0]        r_n,          w_n_nxt;
    // READ: edges elapsed since accept. WRITE: index of byte on the bus.
    logic [2:0]        r_idx,        w_idx_nxt;
    logic [DATA_W-1:0] r_buf,        w_buf_nxt;
    logic [DATA_W-1:0] r_wdata,      w_wdata_nxt;
    logic [ADDR_W-1:0] r_mem_a,      w_mem_a_nxt;
    logic [7:0]        r_mem_dout,   w_mem_dout_nxt;
    logic              r_mem_wr,     w_mem_wr_nxt;
    logic              r_if_finish,  w_if_finish_nxt;
    logic [DATA_W-1:0] r_if_data,    w_if_data_nxt;
    logic              r_lsu_finish, w_lsu_finish_nxt;
    logic [DATA_W-1:0] r_lsu_rdata,  w_lsu_rdata_nxt;

    logic [2:0]        w_idx_p1;
    logic [ADDR_W-1:0] w_next_addr;
    logic [5:0]        w_cap_sh;
    logic [DATA_W-1:0] w_assembled;
    logic [7:0]        w_next_wbyte;
    logic              w_req_ok;

    // A store byte is blocked while it targets the UART window and the
    // UART buffer is full.
    function automatic logic io_blocked(input logic [ADDR_W-1:0] a,
                                        input logic full);
        return (a[17:16] == 2'b11) && full;
    endfunction

    assign w_idx_p1     = r_idx + 3'd1;
    assign w_next_addr  = r_base + ADDR_W'(w_idx_p1);
    // Byte k of a read arrives while r_idx == k+1.
    assign w_cap_sh     = {r_idx - 3'd1, 3'b000};
    assign w_assembled  = r_buf | (DATA_W'(mem_din) << w_cap_sh);
    assign w_next_wbyte = 8'(r_wdata >> {w_idx_p1, 3'b000});
    // No new request while a finish pulse is visible, giving the requester
    // one cycle to drop its enable; none during a flush either.
    assign w_req_ok     = !r_if_finish && !r_lsu_finish && !rollback;

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_base_nxt       = r_base;
        w_n_nxt          = r_n;
        w_idx_nxt        = r_idx;
        w_buf_nxt        = r_buf;
        w_wdata_nxt      = r_wdata;
        w_mem_a_nxt      = r_mem_a;
        w_mem_dout_nxt   = r_mem_dout;
        w_mem_wr_nxt     = 1'b0;
        w_if_finish_nxt  = 1'b0;
        w_if_data_nxt    = r_if_data;
        w_lsu_finish_nxt = 1'b0;
        w_lsu_rdata_nxt  = r_lsu_rdata;

        case (r_state)
            c_IDLE: begin
                if (w_req_ok && lsu_enable) begin
                    w_owner_nxt = c_OWN_LSU;
                    w_base_nxt  = lsu_addr;
                    w_n_nxt     = lsu_size;
                    w_idx_nxt   = 3'd0;
                    w_buf_nxt   = '0;
                    w_wdata_nxt = lsu_wdata;
                    w_mem_a_nxt = lsu_addr;
                    if (lsu_wr) begin
                        w_state_nxt    = c_WRITE;
                        w_mem_dout_nxt = lsu_wdata[7:0];
                        w_mem_wr_nxt   = !io_blocked(lsu_addr, io_buffer_full);
                    end else begin
                        w_state_nxt = c_READ;
                    end
                end else if (w_req_ok && if_enable) begin
                    w_owner_nxt = c_OWN_IF;
                    w_base_nxt  = if_addr;
                    w_n_nxt     = 3'd4;
                    w_idx_nxt   = 3'd0;
                    w_buf_nxt   = '0;
                    w_mem_a_nxt = if_addr;
                    w_state_nxt = c_READ;
                end
            end

            c_READ: begin
                if (rollback) begin
                    w_state_nxt = c_IDLE;
                end else begin
                    w_idx_nxt = w_idx_p1;
                    if (w_idx_p1 < r_n) begin
                        w_mem_a_nxt = w_next_addr;
                    end
                    if (r_idx != 3'd0) begin
                        w_buf_nxt = w_assembled;
                    end
                    if (r_idx == r_n) begin
                        w_state_nxt = c_IDLE;
                        if (r_owner == c_OWN_IF) begin
                            w_if_finish_nxt = 1'b1;
                            w_if_data_nxt   = w_assembled;
                        end else begin
                            w_lsu_finish_nxt = 1'b1;
                            w_lsu_rdata_nxt  = w_assembled;
                        end
                    end
                end
            end

            c_WRITE: begin
                // Committed stores ignore rollback. A byte counts as written
                // only if mem_wr was actually high in the cycle just ended;
                // otherwise (back-pressure or rdy pause) it is re-issued.
                if (r_mem_wr) begin
                    if (w_idx_p1 == r_n) begin
                        w_state_nxt      = c_IDLE;
                        w_lsu_finish_nxt = 1'b1;
                    end else begin
                        w_idx_nxt      = w_idx_p1;
                        w_mem_a_nxt    = w_next_addr;
                        w_mem_dout_nxt = w_next_wbyte;
                        w_mem_wr_nxt   = !io_blocked(w_next_addr, io_buffer_full);
                    end
                end else begin
                    w_mem_wr_nxt = !io_blocked(r_mem_a, io_buffer_full);
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_owner      <= c_OWN_IF;
            r_base       <= '0;
            r_n          <= 3'd0;
            r_idx        <= 3'd0;
            r_buf        <= '0;
            r_wdata      <= '0;
            r_mem_a      <= '0;
            r_mem_dout   <= 8'd0;
            r_mem_wr     <= 1'b0;
            r_if_finish  <= 1'b0;
            r_if_data    <= '0;
            r_lsu_finish <= 1'b0;
            r_lsu_rdata  <= '0;
        end else if (!rdy) begin
            r_mem_wr <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_base       <= w_base_nxt;
            r_n          <= w_n_nxt;
            r_idx        <= w_idx_nxt;
            r_buf        <= w_buf_nxt;
            r_wdata      <= w_wdata_nxt;
            r_mem_a      <= w_mem_a_nxt;
            r_mem_dout   <= w_mem_dout_nxt;
            r_mem_wr     <= w_mem_wr_nxt;
            r_if_finish  <= w_if_finish_nxt;
            r_if_data    <= w_if_data_nxt;
            r_lsu_finish <= w_lsu_finish_nxt;
            r_lsu_rdata  <= w_lsu_rdata_nxt;
        end
    end

    assign if_finish  = r_if_finish;
    assign if_data    = r_if_data;
    assign lsu_finish = r_lsu_finish;
    assign lsu_rdata  = r_lsu_rdata;
    assign mem_a      = r_mem_a;
    assign mem_dout   = r_mem_dout;
    assign mem_wr     = r_mem_wr;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl_arbiter
// Purpose  : Directed self-checking bench for mem_ctrl_arbiter with a
//            registered-read RAM model that stalls with rdy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl_arbiter;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        if_enable;
    logic [31:0] if_addr;
    logic        if_finish;
    logic [31:0] if_data;
    logic        lsu_enable;
    logic        lsu_wr;
    logic [2:0]  lsu_size;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_finish;
    logic [31:0] lsu_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0]  ram [0:65535];

    int n_cmp;
    int n_bad;

    mem_ctrl_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rollback       (rollback),
        .if_enable      (if_enable),
        .if_addr        (if_addr),
        .if_finish      (if_finish),
        .if_data        (if_data),
        .lsu_enable     (lsu_enable),
        .lsu_wr         (lsu_wr),
        .lsu_size       (lsu_size),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_finish     (lsu_finish),
        .lsu_rdata      (lsu_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle read latency; the RAM pipeline freezes with rdy.
    always @(posedge clk) begin
        if (rdy) mem_din <= ram[mem_a[15:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic seen;
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h00;
        ram[16'h0102] = 8'h50; ram[16'h0103] = 8'h00;
        ram[16'h2000] = 8'hAA; ram[16'h2001] = 8'hBB;
        mem_din = 8'h00;
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        if_enable = 1'b0; if_addr = '0;
        lsu_enable = 1'b0; lsu_wr = 1'b0; lsu_size = 3'd0; lsu_addr = '0; lsu_wdata = '0;
        io_buffer_full = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // ---- reset state
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
        chk("rst_if_finish", {31'b0, if_finish}, 32'h0);
        chk("rst_lsu_finish", {31'b0, lsu_finish}, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_lsu_rdata", lsu_rdata, 32'h0);

        // ---- fetch 0x100
        if_enable = 1'b1; if_addr = 32'h100;
        tick(); if_enable = 1'b0;
        chk("f_a0", mem_a, 32'h100);
        chk("f_wr0", {31'b0, mem_wr}, 32'h0);
        tick(); chk("f_a1", mem_a, 32'h101);
        tick(); chk("f_a2", mem_a, 32'h102);
        tick(); chk("f_a3", mem_a, 32'h103);
        chk("f_wr3", {31'b0, mem_wr}, 32'h0);
        tick(); chk("f_fin_early", {31'b0, if_finish}, 32'h0);
        tick(); chk("f_fin", {31'b0, if_finish}, 32'h1);
        chk("f_data", if_data, 32'h00500013);
        tick(); chk("f_fin_drop", {31'b0, if_finish}, 32'h0);
        chk("f_data_hold", if_data, 32'h00500013);

        // ---- simultaneous requests: LSU load wins, fetch follows
        if_enable = 1'b1; if_addr = 32'h100;
        lsu_enable = 1'b1; lsu_wr = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h2000;
        tick(); lsu_enable = 1'b0;
        chk("arb_a0", mem_a, 32'h2000);
        tick(); chk("arb_a1", mem_a, 32'h2001);
        tick(); chk("arb_lfin_early", {31'b0, lsu_finish}, 32'h0);
        tick(); chk("arb_lfin", {31'b0, lsu_finish}, 32'h1);
        chk("arb_rdata", lsu_rdata, 32'h0000BBAA);
        chk("arb_ifin", {31'b0, if_finish}, 32'h0);
        tick(); chk("arb_lfin_drop", {31'b0, lsu_finish}, 32'h0);
        chk("arb_no_fetch_yet", mem_a, 32'h2001);
        tick(); if_enable = 1'b0;
        chk("arb_fetch_a0", mem_a, 32'h100);
        tick(); tick(); tick(); tick();
        chk("arb_fetch_pre", {31'b0, if_finish}, 32'h0);
        tick(); chk("arb_fetch_fin", {31'b0, if_finish}, 32'h1);
        chk("arb_fetch_data", if_data, 32'h00500013);
        tick();

        // ---- store 4 bytes
        lsu_enable = 1'b1; lsu_wr = 1'b1; lsu_size = 3'd4; lsu_addr = 32'h1000; lsu_wdata = 32'hDEADBEEF;
        tick(); lsu_enable = 1'b0;
        chk("st_wr0", {31'b0, mem_wr}, 32'h1);
        chk("st_a0", mem_a, 32'h1000);
        chk("st_d0", {24'b0, mem_dout}, 32'hEF);
        tick(); chk("st_a1", mem_a, 32'h1001); chk("st_d1", {24'b0, mem_dout}, 32'hBE);
        chk("st_wr1", {31'b0, mem_wr}, 32'h1);
        tick(); chk("st_a2", mem_a, 32'h1002); chk("st_d2", {24'b0, mem_dout}, 32'hAD);
        tick(); chk("st_a3", mem_a, 32'h1003); chk("st_d3", {24'b0, mem_dout}, 32'hDE);
        chk("st_wr3", {31'b0, mem_wr}, 32'h1);
        chk("st_fin_early", {31'b0, lsu_finish}, 32'h0);
        tick(); chk("st_fin", {31'b0, lsu_finish}, 32'h1);
        chk("st_wr_fin", {31'b0, mem_wr}, 32'h0);
        tick();

        // ---- IO store with back-pressure
        lsu_enable = 1'b1; lsu_wr = 1'b1; lsu_size = 3'd1; lsu_addr = 32'h30000; lsu_wdata = 32'h55;
        io_buffer_full = 1'b1;
        tick(); lsu_enable = 1'b0;
        chk("io_wr0", {31'b0, mem_wr}, 32'h0);
        chk("io_a0", mem_a, 32'h30000);
        tick(); chk("io_wr1", {31'b0, mem_wr}, 32'h0);
        tick(); chk("io_wr2", {31'b0, mem_wr}, 32'h0);
        io_buffer_full = 1'b0;
        tick(); chk("io_wr3", {31'b0, mem_wr}, 32'h1);
        chk("io_d3", {24'b0, mem_dout}, 32'h55);
        chk("io_fin_early", {31'b0, lsu_finish}, 32'h0);
        tick(); chk("io_fin", {31'b0, lsu_finish}, 32'h1);
        chk("io_wr4", {31'b0, mem_wr}, 32'h0);
        tick();

        // ---- rollback abandons a fetch
        if_enable = 1'b1; if_addr = 32'h100;
        tick(); if_enable = 1'b0;
        tick(); rollback = 1'b1;
        tick(); rollback = 1'b0;
        chk("rb_a_frozen", mem_a, 32'h101);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (if_finish) seen = 1'b1;
        end
        chk("rb_no_finish", {31'b0, seen}, 32'h0);
        chk("rb_a_idle", mem_a, 32'h101);

        // ---- rollback never aborts a store
        lsu_enable = 1'b1; lsu_wr = 1'b1; lsu_size = 3'd4; lsu_addr = 32'h1000; lsu_wdata = 32'h11223344;
        tick(); lsu_enable = 1'b0; rollback = 1'b1;
        chk("rbst_d0", {24'b0, mem_dout}, 32'h44);
        tick(); chk("rbst_d1", {24'b0, mem_dout}, 32'h33);
        chk("rbst_wr1", {31'b0, mem_wr}, 32'h1);
        tick(); chk("rbst_d2", {24'b0, mem_dout}, 32'h22);
        tick(); chk("rbst_d3", {24'b0, mem_dout}, 32'h11);
        chk("rbst_wr3", {31'b0, mem_wr}, 32'h1);
        tick(); chk("rbst_fin", {31'b0, lsu_finish}, 32'h1);
        rollback = 1'b0;
        tick();

        // ---- rdy pause mid-load: finish 2 cycles late, data intact
        lsu_enable = 1'b1; lsu_wr = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h2000;
        tick(); lsu_enable = 1'b0;
        tick(); chk("rdy_a1", mem_a, 32'h2001);
        rdy = 1'b0;
        tick(); chk("rdy_a_frz0", mem_a, 32'h2001);
        chk("rdy_fin0", {31'b0, lsu_finish}, 32'h0);
        tick(); chk("rdy_fin1", {31'b0, lsu_finish}, 32'h0);
        rdy = 1'b1;
        tick(); chk("rdy_fin2", {31'b0, lsu_finish}, 32'h0);
        tick(); chk("rdy_fin", {31'b0, lsu_finish}, 32'h1);
        chk("rdy_rdata", lsu_rdata, 32'h0000BBAA);
        tick();

        // ---- rdy pause during a store forces mem_wr low
        lsu_enable = 1'b1; lsu_wr = 1'b1; lsu_size = 3'd2; lsu_addr = 32'h1000; lsu_wdata = 32'hCAFE;
        tick(); lsu_enable = 1'b0;
        chk("rdyst_wr0", {31'b0, mem_wr}, 32'h1);
        rdy = 1'b0;
        tick(); chk("rdyst_wr_low", {31'b0, mem_wr}, 32'h0);
        chk("rdyst_a_frz", mem_a, 32'h1000);
        rdy = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (lsu_finish) seen = 1'b1;
        end
        chk("rdyst_fin_seen", {31'b0, seen}, 32'h1);

        // ---- 1-byte load: zero-filled above the byte
        lsu_enable = 1'b1; lsu_wr = 1'b0; lsu_size = 3'd1; lsu_addr = 32'h2001;
        tick(); lsu_enable = 1'b0;
        tick(); chk("b1_fin_early", {31'b0, lsu_finish}, 32'h0);
        tick(); chk("b1_fin", {31'b0, lsu_finish}, 32'h1);
        chk("b1_rdata", lsu_rdata, 32'h000000BB);
        tick();

        // ---- address wrap
        lsu_enable = 1'b1; lsu_wr = 1'b0; lsu_size = 3'd2; lsu_addr = 32'hFFFFFFFF;
        tick(); lsu_enable = 1'b0;
        chk("wrap_a0", mem_a, 32'hFFFFFFFF);
        tick(); chk("wrap_a1", mem_a, 32'h0);
        tick(); tick(); chk("wrap_fin", {31'b0, lsu_finish}, 32'h1);
        chk("wrap_rdata", lsu_rdata, 32'h00000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl_arbiter.md
Name: mem_ctrl_arbiter

Overview:
Byte-serial memory controller between the core's requesters and the external RAM/IO bus. It arbitrates between two requesters: the instruction fetcher (4-byte reads) and the LSU (1/2/4-byte loads and stores). It sequences the per-byte mem_a/mem_dout/mem_wr traffic, assembles little-endian read data, and returns a one-cycle finish pulse. It also handles pipeline flush, the rdy pause, and UART back-pressure.

Parameters:
ADDR_W, 32, address width of requests and mem_a
DATA_W, 32, width of assembled data words

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low freezes all state
rollback  in  1  ROB misprediction flush
if_enable  in  1  fetcher requests a 4-byte read
if_addr  in  32  fetch PC
if_finish  out  1  one-cycle pulse: if_data valid
if_data  out  32  fetched instruction
lsu_enable  in  1  LSU request
lsu_wr  in  1  1 = store, 0 = load
lsu_size  in  3  bytes to transfer: 1, 2 or 4
lsu_addr  in  32  byte address
lsu_wdata  in  32  store data; low bytes used
lsu_finish  out  1  one-cycle pulse: access complete
lsu_rdata  out  32  load data, zero-filled above size
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM/IO byte address
mem_wr  out  1  1 = write
io_buffer_full  in  1  UART buffer full

Behaviour:
- States: IDLE, READ, WRITE. Registers: owner (IF/LSU), base address, n (1/2/4), idx, a 32-bit assembly buffer.
- Reset (synchronous, rst=1 at posedge): state=IDLE. Outputs: if_finish=0, lsu_finish=0, if_data=0, lsu_rdata=0, mem_a=0, mem_dout=0, mem_wr=0.
- rdy=0: no register changes except that mem_wr is forced to 0. A transfer resumes exactly where it stopped.
- IDLE accepts a request at a posedge. lsu_enable has priority over if_enable.
  - A read sets state=READ and registers mem_a=addr.
  - A store sets state=WRITE, mem_a=addr, mem_dout=wdata[7:0], mem_wr=1.
  - Enables are ignored in any cycle where if_finish or lsu_finish is high, so a requester has one cycle to drop its enable.
- mem_a, mem_dout and mem_wr are registered.
- READ:
  - Address byte k (k=0..n-1) is registered at edge E_k, where E_0 is the accept edge.
  - RAM data for byte k appears on mem_din during the cycle after E_(k+1) and is captured at E_(k+2) into buffer[8k+7:8k].
  - At E_(n+1): the finish pulse is registered with assembled data, and state returns to IDLE.
  - Read latency from the accept edge to the finish pulse is therefore n+1 cycles: 5 for a fetch.
- WRITE:
  - Byte k is issued at E_k with mem_wr=1.
  - lsu_finish is registered at E_n, so a store takes n cycles. mem_wr=0 in the finish cycle.
- IO back-pressure: if a write targets addr[17:16]==2'b11 and io_buffer_full=1, the controller holds mem_wr=0 and does not advance idx until io_buffer_full=0.
- Addresses increment by 1 per byte with 32-bit wrap: 0xFFFFFFFF+1 -> 0.
- rollback=1:
  - Any READ owned by IF, or a load owned by LSU, is abandoned: state=IDLE, mem_wr=0, and no finish pulse is produced.
  - A WRITE in progress is never aborted, since stores are committed; it completes and pulses lsu_finish.
  - Requests are not accepted in the rollback cycle.
- If rst and rollback are asserted together, reset wins.
- lsu_rdata and if_data hold their last value between pulses. lsu_rdata bits above 8n are 0.
- The two finish signals are never high in the same cycle.

Test Plan:
- Reset, then fetch if_addr=0x100 with RAM bytes 13,00,50,00 → mem_a = 0x100..0x103 on consecutive cycles; if_finish high 5 cycles after accept with if_data=0x00500013; mem_wr stays 0.
- if_enable and lsu_enable (load, size 2, addr 0x2000, bytes 0xAA,0xBB) raised in the same cycle → LSU served first; lsu_rdata=0x0000BBAA; fetch starts the edge after lsu_finish drops.
- Store size 4, addr 0x1000, wdata 0xDEADBEEF → mem_wr=1 for 4 cycles with mem_dout EF,BE,AD,DE and mem_a 0x1000..0x1003; lsu_finish on cycle 4.
- Store size 1 to 0x30000 with io_buffer_full high for 3 cycles → mem_wr held 0 for those 3 cycles, then one write; lsu_finish on the next cycle.
- rollback asserted on the 2nd cycle of a fetch → no if_finish, state IDLE next cycle. rollback during a 4-byte store → all 4 bytes written and lsu_finish pulses.
- rdy low for 2 cycles mid-load → mem_wr=0, mem_a frozen, idx frozen; finish arrives exactly 2 cycles later than the unstalled run with correct data.
